neck_seq_ctrl: RTL and testbench

- Sample scheduler for the necking-detection datapath (ADC, Kalman filter, three differentiators, neck judge), clocked at 100 MHz.
- Generates the sample-rate tick and triggers the ADC conversion on it.
- Chains the enables stage by stage on each stage's finish flag, so the differentiators start only after filtered data is valid.
- Per-stage watchdog, overrun counting and a busy/status view for debug.

---
 rtl/neck_pkg.sv | 39 +++
 rtl/neck_tick_gen.sv | 30 +++
 rtl/neck_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_neck_seq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neck_pkg.sv
// Shared types and constants for the necking-detection sample scheduler.
package neck_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ADC,
    FILT,
    DIF,
    JUDGE
  } state_e;

  typedef enum logic [1:0] {
    STG_ADC   = 2'd0,
    STG_FILT  = 2'd1,
    STG_DIF   = 2'd2,
    STG_JUDGE = 2'd3
  } stage_e;

  localparam int unsigned SAMPLE_DIV_DEF = 200;
  localparam int unsigned TIMEOUT_DEF    = 1023;
  localparam int unsigned WDOG_W         = 16;
  localparam int unsigned OVR_W          = 8;

  // States that are waiting on a datapath stage.
  function automatic logic is_busy(state_e s);
    return (s == ADC) || (s == FILT) || (s == DIF) || (s == JUDGE);
  endfunction

  function automatic stage_e stage_of(state_e s);
    case (s)
      FILT:    return STG_FILT;
      DIF:     return STG_DIF;
      JUDGE:   return STG_JUDGE;
      default: return STG_ADC;
    endcase
  endfunction

endpackage

// File: rtl/neck_tick_gen.sv
// Sample-rate divider: one-cycle tick every DIV clocks while enabled.
module neck_tick_gen
  import neck_pkg::*;
#(
  parameter int unsigned DIV = SAMPLE_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_c = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/neck_seq_ctrl.sv
// Sample scheduler: chains ADC -> Kalman -> differentiators -> judge per tick,
// with per-stage watchdog, overrun counting and status outputs.
module neck_seq_ctrl
  import neck_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_sys,
  input  logic             clear_err,
  input  logic             adc_done,
  input  logic             filt_done,
  input  logic [2:0]       dif_done,
  input  logic             judge_done,
  output logic             adc_start,
  output logic             kalman_start,
  output logic             dif_start,
  output logic             judge_start,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [OVR_W-1:0] overrun_cnt,
  output logic             timeout_err,
  output logic [1:0]       err_stage
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [OVR_W-1:0]  OVR_MAX   = '1;

  state_e            state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [2:0]        collect_q, collect_d;
  logic              tick_c;
  logic              stage_done_c;
  logic              adc_start_d, kalman_start_d, dif_start_d, judge_start_d, busy_d;
  logic [CNT_W-1:0]  sample_cnt_d;
  logic [OVR_W-1:0]  overrun_cnt_d;
  logic              timeout_err_d;
  logic [1:0]        err_stage_d;

  neck_tick_gen #(
    .DIV (SAMPLE_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en_sys),
    .tick_c (tick_c)
  );

  always_comb begin
    state_d        = state_q;
    collect_d      = collect_q;
    stage_done_c   = 1'b0;
    adc_start_d    = 1'b0;
    kalman_start_d = 1'b0;
    dif_start_d    = 1'b0;
    judge_start_d  = 1'b0;
    sample_cnt_d   = sample_cnt;
    overrun_cnt_d  = overrun_cnt;
    timeout_err_d  = timeout_err;
    err_stage_d    = err_stage;

    if (clear_err) begin
      timeout_err_d = 1'b0;
      err_stage_d   = 2'd0;
      overrun_cnt_d = '0;
    end else if (tick_c && (state_q != WAIT_TICK) && (overrun_cnt != OVR_MAX)) begin
      overrun_cnt_d = overrun_cnt + OVR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (en_sys) state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (tick_c) begin
          adc_start_d = 1'b1;
          state_d     = ADC;
        end else if (!en_sys) begin
          state_d = IDLE;
        end
      end
      ADC: begin
        stage_done_c = adc_done;
        if (adc_done) begin
          kalman_start_d = 1'b1;
          state_d        = FILT;
        end
      end
      FILT: begin
        stage_done_c = filt_done;
        if (filt_done) begin
          dif_start_d = 1'b1;
          state_d     = DIF;
        end
      end
      DIF: begin
        // Differentiators finish in any order; wait until all three have reported.
        collect_d    = collect_q | dif_done;
        stage_done_c = &collect_d;
        if (stage_done_c) begin
          judge_start_d = 1'b1;
          collect_d     = '0;
          state_d       = JUDGE;
        end
      end
      JUDGE: begin
        stage_done_c = judge_done;
        if (judge_done) begin
          sample_cnt_d = sample_cnt + CNT_W'(1);
          state_d      = en_sys ? WAIT_TICK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog abort; a done arriving in the same cycle takes precedence.
    if (is_busy(state_q) && !stage_done_c && (wdog_q == WDOG_LAST)) begin
      timeout_err_d = 1'b1;
      err_stage_d   = stage_of(state_q);
      collect_d     = '0;
      state_d       = en_sys ? WAIT_TICK : IDLE;
    end

    if ((state_d != state_q) || !is_busy(state_q)) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + WDOG_W'(1);
    end

    busy_d = is_busy(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wdog_q       <= '0;
      collect_q    <= '0;
      adc_start    <= 1'b0;
      kalman_start <= 1'b0;
      dif_start    <= 1'b0;
      judge_start  <= 1'b0;
      busy         <= 1'b0;
      sample_cnt   <= '0;
      overrun_cnt  <= '0;
      timeout_err  <= 1'b0;
      err_stage    <= 2'd0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      collect_q    <= collect_d;
      adc_start    <= adc_start_d;
      kalman_start <= kalman_start_d;
      dif_start    <= dif_start_d;
      judge_start  <= judge_start_d;
      busy         <= busy_d;
      sample_cnt   <= sample_cnt_d;
      overrun_cnt  <= overrun_cnt_d;
      timeout_err  <= timeout_err_d;
      err_stage    <= err_stage_d;
    end
  end

endmodule

// File: tb/tb_neck_seq_ctrl.sv
// Randomized bench for neck_seq_ctrl against a sample-level behavioural model.
`timescale 1ns/1ps
module tb_neck_seq_ctrl;

  localparam int DIV = 20;
  localparam int TMO = 50;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_sys = 1'b0;
  logic          clear_err = 1'b0;
  logic          adc_done = 1'b0;
  logic          filt_done = 1'b0;
  logic [2:0]    dif_done = 3'b000;
  logic          judge_done = 1'b0;
  logic          adc_start, kalman_start, dif_start, judge_start, busy, timeout_err;
  logic [CW-1:0] sample_cnt;
  logic [7:0]    overrun_cnt;
  logic [1:0]    err_stage;

  always #5 clk = ~clk;

  neck_seq_ctrl #(
    .SAMPLE_DIV (DIV),
    .TIMEOUT    (TMO),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_sys       (en_sys),
    .clear_err    (clear_err),
    .adc_done     (adc_done),
    .filt_done    (filt_done),
    .dif_done     (dif_done),
    .judge_done   (judge_done),
    .adc_start    (adc_start),
    .kalman_start (kalman_start),
    .dif_start    (dif_start),
    .judge_start  (judge_start),
    .busy         (busy),
    .sample_cnt   (sample_cnt),
    .overrun_cnt  (overrun_cnt),
    .timeout_err  (timeout_err),
    .err_stage    (err_stage)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a sample is "running" through stages 0..3 (adc, filt, dif, judge).
  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_RUN  = 2;

  int       m_mode, m_stg, m_age, m_tc, m_cnt, m_ovr, m_estg;
  bit [2:0] m_seen;
  bit       m_adc, m_kal, m_dif, m_jdg, m_err;

  task automatic m_reset();
    m_mode = M_IDLE; m_stg = 0; m_age = 0; m_tc = 0; m_cnt = 0; m_ovr = 0; m_estg = 0;
    m_seen = '0; m_adc = 0; m_kal = 0; m_dif = 0; m_jdg = 0; m_err = 0;
  endtask

  task automatic m_step();
    bit tick, fin;
    tick = en_sys && (m_tc == DIV - 1);
    m_tc = (en_sys && !tick) ? m_tc + 1 : 0;
    m_adc = 0; m_kal = 0; m_dif = 0; m_jdg = 0;
    if (clear_err) begin
      m_err = 0; m_estg = 0; m_ovr = 0;
    end else if (tick && m_mode != M_WAIT && m_ovr < 255) begin
      m_ovr++;
    end
    case (m_mode)
      M_IDLE: if (en_sys) m_mode = M_WAIT;
      M_WAIT: begin
        if (tick) begin
          m_adc = 1; m_mode = M_RUN; m_stg = 0; m_age = 0;
        end else if (!en_sys) begin
          m_mode = M_IDLE;
        end
      end
      default: begin
        case (m_stg)
          0: fin = adc_done;
          1: fin = filt_done;
          2: begin m_seen |= dif_done; fin = (m_seen == 3'b111); end
          default: fin = judge_done;
        endcase
        if (fin) begin
          m_age = 0;
          case (m_stg)
            0: m_kal = 1;
            1: m_dif = 1;
            2: begin m_jdg = 1; m_seen = '0; end
            default: begin
              m_cnt = (m_cnt + 1) % 65536;
              m_mode = en_sys ? M_WAIT : M_IDLE;
            end
          endcase
          m_stg++;
        end else if (m_age + 1 == TMO) begin
          m_err = 1; m_estg = m_stg; m_seen = '0;
          m_mode = en_sys ? M_WAIT : M_IDLE;
        end else begin
          m_age++;
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  task automatic check_all();
    check("adc_start", adc_start, m_adc);
    check("kalman_start", kalman_start, m_kal);
    check("dif_start", dif_start, m_dif);
    check("judge_start", judge_start, m_jdg);
    check("busy", busy, (m_mode == M_RUN));
    check("sample_cnt", sample_cnt, m_cnt);
    check("overrun_cnt", overrun_cnt, m_ovr);
    check("timeout_err", timeout_err, m_err);
    check("err_stage", err_stage, m_estg);
  endtask

  // Responder: delay (cycles after the start pulse) per done line; -1 = never answers.
  int d_adc, d_filt, d_jdg;
  int d_dif[3];
  int c_adc, c_filt, c_jdg;
  int c_dif[3];
  bit rnd_mode = 0;
  bit clr_req = 0;

  function automatic int dly(input int d);
    int r;
    if (d < 0) return 0;
    if (!rnd_mode) return d;
    r = int'($urandom_range(0, 39));
    if (r == 0) return 0;
    if (r == 1) return int'($urandom_range(TMO - 2, TMO + 2));
    return int'($urandom_range(1, 8));
  endfunction

  task automatic set_delays(input int a, input int f, input int d0, input int d1,
                            input int d2, input int j);
    d_adc = a; d_filt = f; d_dif[0] = d0; d_dif[1] = d1; d_dif[2] = d2; d_jdg = j;
  endtask

  task automatic clear_resp();
    c_adc = 0; c_filt = 0; c_jdg = 0;
    for (int i = 0; i < 3; i++) c_dif[i] = 0;
    adc_done = 0; filt_done = 0; dif_done = '0; judge_done = 0; clear_err = 0;
  endtask

  task automatic drive();
    logic [2:0] dd;
    int k;
    adc_done = (c_adc == 1);   if (c_adc > 0) c_adc--;
    filt_done = (c_filt == 1); if (c_filt > 0) c_filt--;
    judge_done = (c_jdg == 1); if (c_jdg > 0) c_jdg--;
    for (int i = 0; i < 3; i++) begin
      dd[i] = (c_dif[i] == 1);
      if (c_dif[i] > 0) c_dif[i]--;
    end
    dif_done = dd;
    if (adc_start) c_adc = dly(d_adc);
    if (kalman_start) c_filt = dly(d_filt);
    if (dif_start) for (int i = 0; i < 3; i++) c_dif[i] = dly(d_dif[i]);
    if (judge_start) c_jdg = dly(d_jdg);
    clear_err = 0;
    if (rnd_mode) begin
      if ($urandom_range(0, 24) == 0) begin
        k = int'($urandom_range(0, 3));
        case (k)
          0: adc_done = 1;
          1: filt_done = 1;
          2: begin k = int'($urandom_range(0, 2)); dif_done[k] = 1'b1; end
          default: judge_done = 1;
        endcase
      end
      if ($urandom_range(0, 299) == 0) clear_err = 1;
      if ($urandom_range(0, 399) == 0) en_sys = ~en_sys;
    end
    if (clr_req) begin clear_err = 1; clr_req = 0; end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
      drive();
    end
  endtask

  task automatic wait_stage(input int stg, input int budget, input string tag);
    int k = 0;
    while (!(m_mode == M_RUN && m_stg == stg) && k < budget) begin
      run(1);
      k++;
    end
    check(tag, (k < budget), 1);
  endtask

  task automatic wait_ovr_sat(input int budget);
    int k = 0;
    while (m_ovr < 255 && k < budget) begin
      run(1);
      k++;
    end
    check("ovr_wait", (k < budget), 1);
  endtask

  int cnt0;

  initial begin
    m_reset();
    clear_resp();
    set_delays(3, 3, 3, 3, 3, 3);
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1;
    en_sys = 1;

    // Nominal loop.
    run(150);
    check("nominal_ovr", overrun_cnt, 0);
    check("nominal_err", timeout_err, 0);

    // Skewed differentiators.
    set_delays(3, 3, 2, 7, 4, 3);
    run(100);

    // Stuck filter, then recover and clear.
    set_delays(3, -1, 3, 3, 3, 3);
    run(150);
    check("stuck_err", timeout_err, 1);
    check("stuck_stage", err_stage, 1);
    set_delays(3, 3, 3, 3, 3, 3);
    run(100);
    clr_req = 1;
    run(3);
    check("clear_err", timeout_err, 0);

    // Random traffic, strays, clears and enable toggles.
    rnd_mode = 1;
    run(3000);
    rnd_mode = 0;
    en_sys = 1;

    // Overrun saturation.
    set_delays(8, 8, 8, 8, 8, 8);
    clr_req = 1;
    run(2);
    wait_ovr_sat(12000);
    run(100);
    check("ovr_sat", overrun_cnt, 255);

    // en_sys drop mid-sample.
    set_delays(3, 3, 3, 3, 3, 3);
    run(60);
    wait_stage(1, 200, "wait_filt");
    cnt0 = m_cnt;
    en_sys = 0;
    run(100);
    check("drop_busy", busy, 0);
    check("drop_cnt", sample_cnt, (cnt0 + 1) % 65536);

    // Judge done on the last watchdog cycle.
    en_sys = 1;
    clr_req = 1;
    set_delays(3, 3, 3, 3, 3, TMO - 1);
    run(2);
    cnt0 = m_cnt;
    wait_stage(3, 200, "wait_judge");
    run(TMO + 5);
    check("race_err", timeout_err, 0);
    check("race_cnt", sample_cnt, (cnt0 + 1) % 65536);

    // Reset while in DIF.
    set_delays(3, 3, 3, 3, 3, 3);
    wait_stage(2, 200, "wait_dif");
    run(1);
    rst_n = 0;
    clear_resp();
    #1;
    check_all();
    run(2);
    rst_n = 1;
    run(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
